// File: rtl/i2c_master_tx.sv
// i2c_master_tx: write-only I2C master. Sends START, the 7-bit target address
// with the write bit, NUM_BYTES payload bytes (each followed by an ACK slot)
// and STOP. SDA is open-drain: it is only ever pulled low or released.
module i2c_master_tx #(
    parameter int         CLK_DIV   = 250,
    parameter logic [6:0] SLV_ADDR  = 7'b1010101,
    parameter int         NUM_BYTES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    input  logic [7:0] data4,
    output logic       SCL,
    inout  wire        SDA,
    output logic       busy,
    output logic       done,
    output logic       ack_error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_DATA     = 3'd4,
        S_DATA_ACK = 3'd5,
        S_STOP     = 3'd6
    } state_t;

    localparam logic [9:0] QMAX      = 10'(CLK_DIV - 1);
    localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);

    state_t     state_r, state_s;
    logic [9:0] qcnt_r, qcnt_s;
    logic [1:0] phase_r, phase_s;
    logic [2:0] bit_r, bit_s;
    logic [2:0] byte_r, byte_s;
    logic [7:0] shadow_r [0:4];
    logic       nack_r;
    logic       scl_r, sda_low_r, busy_r, done_r, ack_error_r;
    logic       scl_s, sda_low_s, busy_s, done_s;
    logic [7:0] tx_byte_s;
    logic       tick_s, period_end_s;

    assign tick_s       = (qcnt_r == QMAX);
    assign period_end_s = tick_s && (phase_r == 2'd3);

    // State and timing counters register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            qcnt_r  <= 10'd0;
            phase_r <= 2'd0;
            bit_r   <= 3'd0;
            byte_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            qcnt_r  <= qcnt_s;
            phase_r <= phase_s;
            bit_r   <= bit_s;
            byte_r  <= byte_s;
        end
    end

    // Next-state and next-counter logic; every transition happens at the end of a bit period.
    always_comb begin
        state_s = state_r;
        qcnt_s  = tick_s ? 10'd0 : (qcnt_r + 10'd1);
        phase_s = tick_s ? (phase_r + 2'd1) : phase_r;
        bit_s   = bit_r;
        byte_s  = byte_r;
        case (state_r)
            S_IDLE: begin
                qcnt_s  = 10'd0;
                phase_s = 2'd0;
                bit_s   = 3'd0;
                byte_s  = 3'd0;
                if (start) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (period_end_s) begin
                    state_s = S_ADDR;
                    bit_s   = 3'd0;
                end else begin
                    state_s = S_START;
                end
            end
            S_ADDR: begin
                if (period_end_s) begin
                    if (bit_r == 3'd7) begin
                        state_s = S_ADDR_ACK;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    state_s = S_ADDR;
                end
            end
            S_ADDR_ACK: begin
                if (period_end_s) begin
                    if (nack_r) begin
                        state_s = S_STOP;
                    end else begin
                        state_s = S_DATA;
                        bit_s   = 3'd0;
                    end
                end else begin
                    state_s = S_ADDR_ACK;
                end
            end
            S_DATA: begin
                if (period_end_s) begin
                    if (bit_r == 3'd7) begin
                        state_s = S_DATA_ACK;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
            S_DATA_ACK: begin
                if (period_end_s) begin
                    if (nack_r || (byte_r == LAST_BYTE)) begin
                        state_s = S_STOP;
                    end else begin
                        state_s = S_DATA;
                        byte_s  = byte_r + 3'd1;
                        bit_s   = 3'd0;
                    end
                end else begin
                    state_s = S_DATA_ACK;
                end
            end
            S_STOP: begin
                if (period_end_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_STOP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Bus levels for the coming cycle, decoded from the next state so the pins come straight from flops.
    always_comb begin
        scl_s     = 1'b1;
        sda_low_s = 1'b0;
        tx_byte_s = 8'h00;
        busy_s    = (state_s != S_IDLE);
        done_s    = (state_r == S_STOP) && (state_s == S_IDLE);
        case (state_s)
            S_IDLE: begin
                scl_s     = 1'b1;
                sda_low_s = 1'b0;
            end
            S_START: begin
                scl_s     = 1'b1;
                sda_low_s = phase_s[1];
            end
            S_ADDR: begin
                tx_byte_s = {SLV_ADDR, 1'b0};
                scl_s     = (phase_s == 2'd1) || (phase_s == 2'd2);
                sda_low_s = ~tx_byte_s[3'd7 - bit_s];
            end
            S_DATA: begin
                case (byte_s)
                    3'd0:    tx_byte_s = shadow_r[0];
                    3'd1:    tx_byte_s = shadow_r[1];
                    3'd2:    tx_byte_s = shadow_r[2];
                    3'd3:    tx_byte_s = shadow_r[3];
                    3'd4:    tx_byte_s = shadow_r[4];
                    default: tx_byte_s = 8'h00;
                endcase
                scl_s     = (phase_s == 2'd1) || (phase_s == 2'd2);
                sda_low_s = ~tx_byte_s[3'd7 - bit_s];
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_s     = (phase_s == 2'd1) || (phase_s == 2'd2);
                sda_low_s = 1'b0;
            end
            S_STOP: begin
                scl_s     = (phase_s != 2'd0);
                sda_low_s = (phase_s != 2'd3);
            end
            default: begin
                scl_s     = 1'b1;
                sda_low_s = 1'b0;
            end
        endcase
    end

    // Output, shadow-payload, ACK-sample and error-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_r       <= 1'b1;
            sda_low_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ack_error_r <= 1'b0;
            nack_r      <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                shadow_r[i] <= 8'h00;
            end
        end else begin
            scl_r     <= scl_s;
            sda_low_r <= sda_low_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            if ((state_r == S_IDLE) && start) begin
                shadow_r[0] <= data0;
                shadow_r[1] <= data1;
                shadow_r[2] <= data2;
                shadow_r[3] <= data3;
                shadow_r[4] <= data4;
                ack_error_r <= 1'b0;
                nack_r      <= 1'b0;
            end else if (((state_r == S_ADDR_ACK) || (state_r == S_DATA_ACK)) && tick_s) begin
                if (phase_r == 2'd1) begin
                    nack_r <= SDA;
                end else if ((phase_r == 2'd3) && nack_r) begin
                    ack_error_r <= 1'b1;
                end else begin
                    nack_r <= nack_r;
                end
            end else begin
                ack_error_r <= ack_error_r;
            end
        end
    end

    assign SCL       = scl_r;
    assign SDA       = sda_low_r ? 1'b0 : 1'bz;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ack_error = ack_error_r;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx with an open-drain bus and a byte-level
// responder that ACKs address 0x55 (write) and can NACK a chosen byte.
module tb_i2c_master_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data0 = 8'h11, data1 = 8'h22, data2 = 8'h33, data3 = 8'h44, data4 = 8'h55;
    logic       scl_w, busy, done, ack_error;
    wire        sda_line;
    logic       resp_low = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Responder/monitor state
    int         nack_at = -1;   // 0: NACK address, k: NACK data byte k (1-based), -1: never
    int         bit_idx = 0;
    int         byte_no = 0;
    int         starts = 0, stops = 0, viol = 0;
    logic       in_frame = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] shreg = 8'h00;
    logic [7:0] rx_q[$];

    pullup (sda_line);
    assign sda_line = resp_low ? 1'b0 : 1'bz;

    i2c_master_tx #(.CLK_DIV(4), .SLV_ADDR(7'b1010101), .NUM_BYTES(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3), .data4(data4),
        .SCL(scl_w), .SDA(sda_line), .busy(busy), .done(done), .ack_error(ack_error)
    );

    always #5 clk = ~clk;

    // Bus monitor and responder, sampled on the falling clock edge
    always @(negedge clk) begin
        if (reset) begin
            bit_idx  = 0;
            resp_low = 1'b0;
            in_frame = 1'b0;
        end else if (prev_scl && scl_w && prev_sda && !sda_line) begin
            if (in_frame) viol++;
            starts++;
            in_frame = 1'b1;
            bit_idx  = 0;
            byte_no  = 0;
        end else if (prev_scl && scl_w && !prev_sda && sda_line) begin
            if (!in_frame) viol++;
            stops++;
            in_frame = 1'b0;
            bit_idx  = 0;
            resp_low = 1'b0;
        end else if (!prev_scl && scl_w) begin
            if (sda_line != prev_sda) viol++;
            if (bit_idx < 8) begin
                shreg = {shreg[6:0], sda_line};
                bit_idx++;
            end else if (bit_idx == 8) begin
                bit_idx = 9;
            end
        end else if (prev_scl && !scl_w) begin
            if (bit_idx == 8 && in_frame) begin
                rx_q.push_back(shreg);
                if (byte_no == 0) resp_low = (shreg == 8'hAA) && (nack_at != 0);
                else              resp_low = (nack_at != byte_no);
            end else if (bit_idx == 9) begin
                resp_low = 1'b0;
                bit_idx  = 0;
                byte_no++;
            end
        end
        prev_scl = scl_w;
        prev_sda = sda_line;
    end

    // Runs one transaction from start request to a few cycles past done.
    // mode 1 re-pulses start and overwrites data0 while busy.
    task automatic do_txn(input int mode, output int busy_cyc, output int done_cnt, output int done_n);
        busy_cyc = 0; done_cnt = 0; done_n = -1;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            #1;
            start = (mode == 1) && (n == 50);
            if ((mode == 1) && (n == 50)) data0 = 8'hFF;
            if ((done_n >= 0) && (n >= done_n + 8)) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (scl_w !== 1'b1)    begin n_fail++; $display("FAIL reset_scl got %0b want 1", scl_w); end
        n_checks++; if (sda_line !== 1'b1) begin n_fail++; $display("FAIL reset_sda got %0b want 1", sda_line); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (ack_error !== 1'b0) begin n_fail++; $display("FAIL reset_ack_error got %0b want 0", ack_error); end
        #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0; reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_during_reset busy got %0b want 0", busy); end
    endtask

    task automatic test_full(input string name);
        int bc, dc, dn, base, s0, p0;
        logic [7:0] exp_b [6];
        exp_b = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        nack_at = -1; base = rx_q.size(); s0 = starts; p0 = stops;
        do_txn(0, bc, dc, dn);
        n_checks++; if (bc !== 896) begin n_fail++; $display("FAIL %s busy_cycles got %0d want 896", name, bc); end
        n_checks++; if (dc !== 1)   begin n_fail++; $display("FAIL %s done_pulses got %0d want 1", name, dc); end
        n_checks++; if (dn !== 896) begin n_fail++; $display("FAIL %s done_cycle got %0d want 896", name, dn); end
        n_checks++; if (ack_error !== 1'b0) begin n_fail++; $display("FAIL %s ack_error got %0b want 0", name, ack_error); end
        n_checks++; if (rx_q.size() - base !== 6) begin n_fail++; $display("FAIL %s byte_count got %0d want 6", name, rx_q.size() - base); end
        for (int i = 0; i < 6; i++) begin
            if (base + i < rx_q.size()) begin
                n_checks++;
                if (rx_q[base + i] !== exp_b[i]) begin n_fail++; $display("FAIL %s byte%0d got %h want %h", name, i, rx_q[base + i], exp_b[i]); end
            end
        end
        n_checks++; if (starts - s0 !== 1 || stops - p0 !== 1) begin n_fail++; $display("FAIL %s start_stop got %0d/%0d want 1/1", name, starts - s0, stops - p0); end
    endtask

    task automatic test_addr_nack();
        int bc, dc, dn, base, p0;
        nack_at = 0; base = rx_q.size(); p0 = stops;
        do_txn(0, bc, dc, dn);
        n_checks++; if (dn !== 176) begin n_fail++; $display("FAIL addr_nack done_cycle got %0d want 176", dn); end
        n_checks++; if (bc !== 176) begin n_fail++; $display("FAIL addr_nack busy_cycles got %0d want 176", bc); end
        n_checks++; if (ack_error !== 1'b1) begin n_fail++; $display("FAIL addr_nack ack_error got %0b want 1", ack_error); end
        n_checks++; if (rx_q.size() - base !== 1) begin n_fail++; $display("FAIL addr_nack byte_count got %0d want 1", rx_q.size() - base); end
        n_checks++; if (rx_q.size() > base && rx_q[base] !== 8'hAA) begin n_fail++; $display("FAIL addr_nack addr got %h want aa", rx_q[base]); end
        n_checks++; if (stops - p0 !== 1) begin n_fail++; $display("FAIL addr_nack stops got %0d want 1", stops - p0); end
        nack_at = -1;
    endtask

    task automatic test_data_nack();
        int bc, dc, dn, base, p0;
        logic [7:0] exp_b [4];
        exp_b = '{8'hAA, 8'h11, 8'h22, 8'h33};
        nack_at = 3; base = rx_q.size(); p0 = stops;
        do_txn(0, bc, dc, dn);
        n_checks++; if (bc !== 608) begin n_fail++; $display("FAIL data_nack busy_cycles got %0d want 608", bc); end
        n_checks++; if (dc !== 1)   begin n_fail++; $display("FAIL data_nack done_pulses got %0d want 1", dc); end
        n_checks++; if (ack_error !== 1'b1) begin n_fail++; $display("FAIL data_nack ack_error got %0b want 1", ack_error); end
        n_checks++; if (rx_q.size() - base !== 4) begin n_fail++; $display("FAIL data_nack byte_count got %0d want 4", rx_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            if (base + i < rx_q.size()) begin
                n_checks++;
                if (rx_q[base + i] !== exp_b[i]) begin n_fail++; $display("FAIL data_nack byte%0d got %h want %h", i, rx_q[base + i], exp_b[i]); end
            end
        end
        n_checks++; if (stops - p0 !== 1) begin n_fail++; $display("FAIL data_nack stops got %0d want 1", stops - p0); end
        nack_at = -1;
    endtask

    task automatic test_ignore_start();
        int bc, dc, dn, base;
        base = rx_q.size();
        do_txn(1, bc, dc, dn);
        n_checks++; if (bc !== 896) begin n_fail++; $display("FAIL ignore_start busy_cycles got %0d want 896", bc); end
        n_checks++; if (dc !== 1)   begin n_fail++; $display("FAIL ignore_start done_pulses got %0d want 1", dc); end
        n_checks++; if (rx_q.size() - base !== 6) begin n_fail++; $display("FAIL ignore_start byte_count got %0d want 6", rx_q.size() - base); end
        n_checks++; if (rx_q.size() > base + 1 && rx_q[base + 1] !== 8'h11) begin n_fail++; $display("FAIL ignore_start data0 got %h want 11", rx_q[base + 1]); end
        data0 = 8'h11;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (360) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid busy_before got %0b want 1", busy); end
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (scl_w !== 1'b1)    begin n_fail++; $display("FAIL reset_mid scl got %0b want 1", scl_w); end
        n_checks++; if (sda_line !== 1'b1) begin n_fail++; $display("FAIL reset_mid sda got %0b want 1", sda_line); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_mid busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_mid done got %0b want 0", done); end
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        test_full("after_reset");
    endtask

    initial begin
        test_reset();
        test_full("full");
        test_addr_nack();
        test_full("after_nack");
        test_data_nack();
        test_ignore_start();
        test_reset_mid();
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL bus_protocol violations got %0d want 0", viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
